// File: rtl/pattern_player.sv
// Pattern player: plays a writable sample table in one-shot, loop or
// ping-pong order over a valid/ready stream.
module pattern_player #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] MAX_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        MODE_ONE = 2'd0;
  localparam logic [1:0]        MODE_PP  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                dir_q, dir_d;      // 0 = counting up, 1 = counting down
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   tbl_q [DEPTH];
  logic                tbl_we;
  logic [ADDR_W-1:0]   last_clamped;
  logic [ADDR_W-1:0]   nxt_idx;
  logic                nxt_dir;
  logic                at_last;
  logic                beat;

  assign tbl_we       = wr_en && (state_q == IDLE) && (wr_addr <= MAX_IDX);
  assign last_clamped = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
  assign at_last      = (idx_q == last_q);
  assign beat         = valid_q && data_ready;

  // Sample table; reset reloads the ramp pattern (i+1)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_q[i] <= DATA_W'(i + 1);
      end
    end else if (tbl_we) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // Index/direction that follow the current one for the latched mode
  always_comb begin
    nxt_idx = idx_q;
    nxt_dir = dir_q;
    if (mode_q == MODE_PP) begin
      if (last_q == '0) begin
        nxt_idx = '0;
      end else if (!dir_q) begin
        if (at_last) begin
          nxt_idx = idx_q - ADDR_W'(1);
          nxt_dir = 1'b1;
        end else begin
          nxt_idx = idx_q + ADDR_W'(1);
        end
      end else begin
        if (idx_q == '0) begin
          nxt_idx = ADDR_W'(1);
          nxt_dir = 1'b0;
        end else begin
          nxt_idx = idx_q - ADDR_W'(1);
        end
      end
    end else begin
      nxt_idx = at_last ? '0 : idx_q + ADDR_W'(1);
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
      last_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    last_d  = last_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          idx_d   = '0;
          dir_d   = 1'b0;
          mode_d  = mode;
          last_d  = last_clamped;
          dout_d  = tbl_q[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          // A beat accepted this cycle already counts; a pending one is dropped
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (beat) begin
          if ((mode_q == MODE_ONE) && at_last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = nxt_idx;
            dir_d  = nxt_dir;
            dout_d = tbl_q[nxt_idx];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player (default parameters).
module tb_pattern_player;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] last_idx;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_player dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .last_idx   (last_idx),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [3:0] l);
    mode = m; last_idx = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [7:0] loop_exp [7]  = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1};
  logic [7:0] pp_exp   [11] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3};

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; last_idx = 4'd0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; data_ready = 1'b1;
    tick(); tick();
    chk("rst_data",  32'(data_out),   32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_done",  32'(done),       32'h0);
    sys_rst_n = 1'b1;
    tick();

    // start together with stop must not launch
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy",  32'(busy),       32'h0);
    chk("start_stop_valid", 32'(data_valid), 32'h0);

    // One-shot 0..9 at full throughput
    pulse_start(2'd0, 4'd9);
    chk("os_busy", 32'(busy), 32'h1);
    for (int k = 1; k <= 10; k++) begin
      chk("os_data",  32'(data_out),   32'(k));
      chk("os_valid", 32'(data_valid), 32'h1);
      tick();
    end
    chk("os_end_valid", 32'(data_valid), 32'h0);
    chk("os_end_busy",  32'(busy),       32'h0);
    chk("os_end_done",  32'(done),       32'h1);
    tick();
    chk("os_done_1cyc", 32'(done),       32'h0);

    // Loop L=2, then stop
    pulse_start(2'd1, 4'd2);
    for (int k = 0; k < 7; k++) begin
      chk("loop_data",  32'(data_out),   32'(loop_exp[k]));
      chk("loop_valid", 32'(data_valid), 32'h1);
      tick();
    end
    do_stop();
    chk("loop_stop_valid", 32'(data_valid), 32'h0);
    chk("loop_stop_busy",  32'(busy),       32'h0);
    chk("loop_stop_done",  32'(done),       32'h0);
    chk("loop_stop_hold",  32'(data_out),   32'h2);

    // Ping-pong L=3
    pulse_start(2'd2, 4'd3);
    for (int k = 0; k < 11; k++) begin
      chk("pp_data", 32'(data_out), 32'(pp_exp[k]));
      tick();
    end
    do_stop();
    chk("pp_stop_valid", 32'(data_valid), 32'h0);

    // Ping-pong L=0 repeats table[0]
    pulse_start(2'd2, 4'd0);
    for (int k = 0; k < 3; k++) begin
      chk("pp0_data",  32'(data_out),   32'h1);
      chk("pp0_valid", 32'(data_valid), 32'h1);
      tick();
    end
    do_stop();

    // One-shot L=15 with ready pattern 1,0,0,1,...
    begin
      int v;
      int c;
      v = 1;
      pulse_start(2'd0, 4'd15);
      for (c = 0; c < 64; c++) begin
        data_ready = ((c % 4) == 0) || ((c % 4) == 3);
        chk("bp_data",  32'(data_out),   32'(v));
        chk("bp_valid", 32'(data_valid), 32'h1);
        tick();
        if (data_ready) begin
          if (v == 16) break;
          v++;
        end
      end
      chk("bp_last_value", 32'(v),          32'd16);
      chk("bp_end_valid",  32'(data_valid), 32'h0);
      chk("bp_end_done",   32'(done),       32'h1);
      data_ready = 1'b1;
      tick();
    end

    // Table writes in IDLE take effect; write during RUN is ignored
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hA5;
    tick();
    wr_addr = 4'd1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    pulse_start(2'd0, 4'd1);
    chk("wr_data0", 32'(data_out), 32'hA5);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("wr_data1", 32'(data_out), 32'h5A);
    tick();
    chk("wr_done", 32'(done), 32'h1);
    tick();
    pulse_start(2'd0, 4'd1);
    chk("wr_replay0", 32'(data_out), 32'hA5);
    tick();
    chk("wr_run_ignored", 32'(data_out), 32'h5A);
    tick();
    tick();

    // Reset mid-loop, then table reload
    pulse_start(2'd1, 4'd2);
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_data",  32'(data_out),   32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_busy",  32'(busy),       32'h0);
    chk("mid_rst_done",  32'(done),       32'h0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'h0);
    chk("post_rst_done", 32'(done), 32'h0);
    pulse_start(2'd0, 4'd0);
    chk("reload_data",  32'(data_out),   32'h1);
    chk("reload_valid", 32'(data_valid), 32'h1);
    tick();
    chk("reload_done",  32'(done),       32'h1);
    chk("reload_end",   32'(data_valid), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter DEPTH, default 16, number of table entries (2..256).
REQ-003 Parameter ADDR_W, default 4, index width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin playback; sampled only in IDLE.
REQ-007 stop  input  1  abort playback; sampled only in RUN.
REQ-008 mode  input  2  0 one-shot, 1 loop, 2 ping-pong, 3 treated as loop; latched at start.
REQ-009 last_idx  input  ADDR_W  final table index of the sequence; latched at start.
REQ-010 wr_en  input  1  table write strobe.
REQ-011 wr_addr  input  ADDR_W  table write index.
REQ-012 wr_data  input  DATA_W  table write value.
REQ-013 data_out  output  DATA_W  current sample, registered.
REQ-014 data_valid  output  1  data_out holds a sample offered downstream.
REQ-015 data_ready  input  1  downstream accepts; a beat transfers when data_valid and data_ready are both 1.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse on one-shot completion.

Function
REQ-018 FSM SHALL have two states: IDLE and RUN.
REQ-019 IDLE -> RUN on start=1 and stop=0; next cycle: busy=1, data_valid=1, data_out=table[0], index=0, direction=up.
REQ-020 start=1 with stop=1 in IDLE: stay in IDLE; start in RUN: ignored.
REQ-021 Latched last_idx > DEPTH-1 SHALL be clamped to DEPTH-1.
REQ-022 data_out and data_valid SHALL hold unchanged while data_valid=1 and data_ready=0.
REQ-023 Each transferred beat SHALL present the next sample on the following cycle (one sample per cycle at full throughput).
REQ-024 Loop: index sequence 0,1,..,L,0,1,.. with no gap at wrap.
REQ-025 Ping-pong: 0,1,..,L,L-1,..,0,1,..; endpoints emitted once per turn; L=0 repeats table[0].
REQ-026 One-shot: after the beat at index L transfers, next cycle data_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
REQ-027 stop=1 in RUN: next cycle IDLE, data_valid=0, busy=0, done stays 0; a beat transferring in the same cycle counts as delivered; a pending unaccepted beat is dropped.
REQ-028 Table writes SHALL be accepted only in IDLE with wr_addr <= DEPTH-1; otherwise ignored; written value is readable by the next start.
REQ-029 data_out SHALL keep its last value when data_valid=0.
REQ-030 Index arithmetic SHALL use ADDR_W bits with no out-of-range table access.

Reset
REQ-031 sys_rst_n=0 SHALL immediately force: state IDLE, data_out=0, data_valid=0, busy=0, done=0, index=0, direction=up.
REQ-032 Reset SHALL reload table[i] = (i+1) mod 2^DATA_W for i = 0..DEPTH-1, discarding prior writes.
REQ-033 Reset asserted mid-playback SHALL abort without a done pulse; after release the block stays IDLE until start.

Verification
REQ-034 Defaults, mode=0, last_idx=9, data_ready=1, pulse start -> data_out 1..10 on 10 consecutive cycles, then done pulse, data_valid=0.
REQ-035 mode=1, last_idx=2, data_ready=1 -> 1,2,3,1,2,3,... with no gaps; stop -> data_valid=0 next cycle, no done.
REQ-036 mode=2, last_idx=3 -> 1,2,3,4,3,2,1,2,3,4,...
REQ-037 mode=0, data_ready toggled 1,0,0,1,... -> each value held while ready=0, no value skipped or repeated, done after value 16 with last_idx=15.
REQ-038 In IDLE write table[0]=8'hA5, table[1]=8'h5A, then mode=0, last_idx=1, start -> A5, 5A; write attempted in RUN -> no effect.
REQ-039 Assert sys_rst_n=0 mid-loop -> outputs 0 immediately; after release, start with last_idx=0, mode=0 -> data_out=1, done.
